// File: rtl/ave8_thresh_pkg.sv
// ave8_thresh_pkg
// Shared definitions for the threshold/alarm stage that follows the 8-sample
// moving-average block.
//   AVE8_DW      : default width of an average value (matches the averaging stage)
//   DCNT_W       : width of the debounce counter
//   deb_state_e  : hysteresis FSM state encoding
//   state_is_alarm() : alarm level implied by an FSM state
package ave8_thresh_pkg;

  localparam int unsigned AVE8_DW = 8;
  localparam int unsigned DCNT_W  = 4;

  // The two alarm-high states share bit 1, so the alarm level is a plain register bit.
  typedef enum logic [1:0] {
    StBelow     = 2'd0,
    StArming    = 2'd1,
    StAbove     = 2'd2,
    StDisarming = 2'd3
  } deb_state_e;

  function automatic logic state_is_alarm(input deb_state_e s);
    return (s == StAbove) || (s == StDisarming);
  endfunction

endpackage

// File: rtl/ave8_thresh_deb.sv
// ave8_thresh_deb
// Hysteresis FSM with debounce counter. A state change needs DEB consecutive
// qualifying samples; any non-qualifying sample restarts the count.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_valid        : a new sample is present this cycle
//   i_arm_q        : current sample qualifies for arming (avg > thr_hi)
//   i_disarm_q     : current sample qualifies for disarming (avg < thr_lo)
//   o_state        : registered FSM state
//   o_rise_stb     : combinational strobe, this cycle's sample completes arming
//   o_fall_stb     : combinational strobe, this cycle's sample completes disarming
module ave8_thresh_deb
  import ave8_thresh_pkg::*;
#(
  parameter int unsigned DEB = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_arm_q,
  input  logic       i_disarm_q,
  output deb_state_e o_state,
  output logic       o_rise_stb,
  output logic       o_fall_stb
);

  localparam logic [DCNT_W-1:0] DebCnt = DCNT_W'(DEB);

  deb_state_e        r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic [DCNT_W-1:0] w_dcnt_inc;
  logic              w_arm_done;
  logic              w_disarm_done;

  assign w_dcnt_inc = r_dcnt + DCNT_W'(1);

  // A qualifying sample finishes the debounce either directly from the stable
  // state (DEB == 1) or when the running count reaches DEB.
  assign w_arm_done = i_valid && i_arm_q &&
                      (((r_state == StBelow) && (DebCnt == DCNT_W'(1))) ||
                       ((r_state == StArming) && (w_dcnt_inc == DebCnt)));

  assign w_disarm_done = i_valid && i_disarm_q &&
                         (((r_state == StAbove) && (DebCnt == DCNT_W'(1))) ||
                          ((r_state == StDisarming) && (w_dcnt_inc == DebCnt)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StBelow;
      r_dcnt  <= '0;
    end else if (i_valid) begin
      unique case (r_state)
        StBelow: begin
          if (w_arm_done) begin
            r_state <= StAbove;
            r_dcnt  <= '0;
          end else if (i_arm_q) begin
            r_state <= StArming;
            r_dcnt  <= DCNT_W'(1);
          end
        end
        StArming: begin
          if (w_arm_done) begin
            r_state <= StAbove;
            r_dcnt  <= '0;
          end else if (i_arm_q) begin
            r_dcnt  <= w_dcnt_inc;
          end else begin
            r_state <= StBelow;
            r_dcnt  <= '0;
          end
        end
        StAbove: begin
          if (w_disarm_done) begin
            r_state <= StBelow;
            r_dcnt  <= '0;
          end else if (i_disarm_q) begin
            r_state <= StDisarming;
            r_dcnt  <= DCNT_W'(1);
          end
        end
        StDisarming: begin
          if (w_disarm_done) begin
            r_state <= StBelow;
            r_dcnt  <= '0;
          end else if (i_disarm_q) begin
            r_dcnt  <= w_dcnt_inc;
          end else begin
            r_state <= StAbove;
            r_dcnt  <= '0;
          end
        end
        default: begin
          r_state <= StBelow;
          r_dcnt  <= '0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_rise_stb = w_arm_done;
  assign o_fall_stb = w_disarm_done;

endmodule

// File: rtl/ave8_thresh.sv
// ave8_thresh
// Watches each new moving average against a hysteresis window, raises a
// debounced alarm level with one-cycle rise/fall pulses, and tracks the peak
// average plus a saturating count of alarm rises (both cleared by clr).
// Ports:
//   CLOCK, RESET : clock (rising edge), asynchronous active-high reset
//   avg          : average value, MSB at index 0
//   avg_valid    : avg holds a new average this cycle
//   thr_hi       : arm threshold (avg > thr_hi qualifies)
//   thr_lo       : disarm threshold (avg < thr_lo qualifies)
//   clr          : synchronous clear of peak and event_cnt
//   alarm        : alarm level
//   alarm_rise   : one-cycle pulse on alarm 0->1
//   alarm_fall   : one-cycle pulse on alarm 1->0
//   peak         : largest avg seen since clear/reset
//   event_cnt    : number of alarm rises, saturating
module ave8_thresh
  import ave8_thresh_pkg::*;
#(
  parameter int unsigned DW  = AVE8_DW,
  parameter int unsigned DEB = 3,
  parameter int unsigned CW  = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [0:DW-1] avg,
  input  logic          avg_valid,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  input  logic          clr,
  output logic          alarm,
  output logic          alarm_rise,
  output logic          alarm_fall,
  output logic [DW-1:0] peak,
  output logic [CW-1:0] event_cnt
);

  deb_state_e    w_state;
  logic          w_arm_q;
  logic          w_disarm_q;
  logic          w_rise_stb;
  logic          w_fall_stb;

  logic          r_rise;
  logic          r_fall;
  logic [DW-1:0] r_peak;
  logic [CW-1:0] r_event_cnt;

  // Strict comparisons: equality never qualifies. A crossed window
  // (thr_lo > thr_hi) is deliberately not special-cased.
  assign w_arm_q    = avg > thr_hi;
  assign w_disarm_q = avg < thr_lo;

  ave8_thresh_deb #(
    .DEB (DEB)
  ) u_deb (
    .i_clk      (CLOCK),
    .i_rst      (RESET),
    .i_valid    (avg_valid),
    .i_arm_q    (w_arm_q),
    .i_disarm_q (w_disarm_q),
    .o_state    (w_state),
    .o_rise_stb (w_rise_stb),
    .o_fall_stb (w_fall_stb)
  );

  // Pulses are registered on the same edge that moves the FSM, so they line up
  // with the alarm level change.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_stb;
      r_fall <= w_fall_stb;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_peak <= '0;
    end else if (clr) begin
      r_peak <= avg_valid ? avg : '0;
    end else if (avg_valid && (avg > r_peak)) begin
      r_peak <= avg;
    end
  end

  // clr wins over a same-cycle rise: that rise is dropped from the count.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_event_cnt <= '0;
    end else if (clr) begin
      r_event_cnt <= '0;
    end else if (w_rise_stb && (r_event_cnt != '1)) begin
      r_event_cnt <= r_event_cnt + CW'(1);
    end
  end

  assign alarm      = state_is_alarm(w_state);
  assign alarm_rise = r_rise;
  assign alarm_fall = r_fall;
  assign peak       = r_peak;
  assign event_cnt  = r_event_cnt;

endmodule

// File: tb/tb_ave8_thresh.sv
module tb_ave8_thresh;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEB = 3;
  localparam int unsigned CW  = 2;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [0:DW-1] avg;
  logic          avg_valid;
  logic [DW-1:0] thr_hi;
  logic [DW-1:0] thr_lo;
  logic          clr;
  logic          alarm;
  logic          alarm_rise;
  logic          alarm_fall;
  logic [DW-1:0] peak;
  logic [CW-1:0] event_cnt;

  always #5 CLOCK = ~CLOCK;

  ave8_thresh #(
    .DW  (DW),
    .DEB (DEB),
    .CW  (CW)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .avg        (avg),
    .avg_valid  (avg_valid),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .clr        (clr),
    .alarm      (alarm),
    .alarm_rise (alarm_rise),
    .alarm_fall (alarm_fall),
    .peak       (peak),
    .event_cnt  (event_cnt)
  );

  typedef struct packed {
    logic          alarm;
    logic          rise;
    logic          fall;
    logic [DW-1:0] peak;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_tests   = 0;
  int n_fail    = 0;
  int rise_seen = 0;

  // Reference model: 0 BELOW, 1 ARMING, 2 ABOVE, 3 DISARMING
  int            m_st;
  int            m_d;
  logic [DW-1:0] m_peak;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_d    = 0;
    m_peak = '0;
    m_cnt  = '0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, push model expectation, then pop and compare.
  task automatic step(input logic v, input int a, input logic c);
    exp_t e;
    logic r;
    logic f;
    logic [DW-1:0] av;
    av        = DW'(a);
    avg       = av;
    avg_valid = v;
    clr       = c;
    r = 1'b0;
    f = 1'b0;
    if (v) begin
      case (m_st)
        0: if (av > thr_hi) begin
             if (DEB == 1) begin m_st = 2; r = 1'b1; end
             else begin m_st = 1; m_d = 1; end
           end
        1: if (av > thr_hi) begin
             if (m_d + 1 == DEB) begin m_st = 2; m_d = 0; r = 1'b1; end
             else m_d = m_d + 1;
           end else begin m_st = 0; m_d = 0; end
        2: if (av < thr_lo) begin
             if (DEB == 1) begin m_st = 0; f = 1'b1; end
             else begin m_st = 3; m_d = 1; end
           end
        default: if (av < thr_lo) begin
             if (m_d + 1 == DEB) begin m_st = 0; m_d = 0; f = 1'b1; end
             else m_d = m_d + 1;
           end else begin m_st = 2; m_d = 0; end
      endcase
    end
    if (c) m_peak = v ? av : '0;
    else if (v && av > m_peak) m_peak = av;
    if (c) m_cnt = '0;
    else if (r && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    e.alarm = (m_st == 2) || (m_st == 3);
    e.rise  = r;
    e.fall  = f;
    e.peak  = m_peak;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(posedge CLOCK);
    #1;
    avg_valid = 1'b0;
    clr       = 1'b0;
    e = sb_q.pop_front();
    chk("alarm", 32'(alarm), 32'(e.alarm));
    chk("alarm_rise", 32'(alarm_rise), 32'(e.rise));
    chk("alarm_fall", 32'(alarm_fall), 32'(e.fall));
    chk("peak", 32'(peak), 32'(e.peak));
    chk("event_cnt", 32'(event_cnt), 32'(e.cnt));
    if (alarm_rise) rise_seen++;
  endtask

  task automatic vstep(input int a);
    step(1'b1, a, 1'b0);
  endtask

  initial begin
    RESET     = 1'b1;
    avg       = '0;
    avg_valid = 1'b0;
    clr       = 1'b0;
    thr_hi    = 8'd100;
    thr_lo    = 8'd80;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_rise", 32'(alarm_rise), 0);
    chk("rst_fall", 32'(alarm_fall), 0);
    chk("rst_peak", 32'(peak), 0);
    chk("rst_cnt", 32'(event_cnt), 0);
    RESET = 1'b0;
    step(1'b0, 0, 1'b0);

    // Arm: 101,120,105
    vstep(101); vstep(120); vstep(105);
    chk("t1_alarm", 32'(alarm), 1);
    chk("t1_rise", 32'(alarm_rise), 1);
    chk("t1_cnt", 32'(event_cnt), 1);
    chk("t1_peak", 32'(peak), 120);
    step(1'b0, 0, 1'b0);
    chk("t1_rise_1cyc", 32'(alarm_rise), 0);

    // In ABOVE: equality at thr_lo never disarms, then 79 x3 does
    repeat (4) vstep(80);
    chk("t3_hold", 32'(alarm), 1);
    vstep(79); vstep(79);
    chk("t3_not_yet", 32'(alarm), 1);
    vstep(79);
    chk("t3_fall", 32'(alarm_fall), 1);
    chk("t3_alarm0", 32'(alarm), 0);
    step(1'b0, 0, 1'b0);

    // From BELOW: debounce restart, then equality at thr_hi
    vstep(101); vstep(101); vstep(99); vstep(101);
    chk("t2_restart", 32'(alarm), 0);
    repeat (5) vstep(100);
    chk("t2_equal", 32'(alarm), 0);

    // Saturation with CW=2
    step(1'b0, 0, 1'b1);
    rise_seen = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (3) vstep(150);
      chk("t4_cnt", 32'(event_cnt), (k < 3) ? k + 1 : 3);
      repeat (3) vstep(10);
    end
    chk("t4_rises", rise_seen, 4);

    // clr on the arming-complete strobe
    step(1'b0, 0, 1'b1);
    vstep(200); vstep(200);
    step(1'b1, 150, 1'b1);
    chk("t5_cnt", 32'(event_cnt), 0);
    chk("t5_peak", 32'(peak), 150);
    chk("t5_rise", 32'(alarm_rise), 1);
    chk("t5_alarm", 32'(alarm), 1);
    repeat (3) vstep(10);
    chk("t5_below", 32'(alarm), 0);

    // Reset mid-debounce discards the partial count
    vstep(150); vstep(150);
    #2 RESET = 1'b1;
    #1;
    chk("t6_async_peak", 32'(peak), 0);
    model_reset();
    @(posedge CLOCK);
    #1 RESET = 1'b0;
    vstep(150);
    chk("t6_no_alarm", 32'(alarm), 0);
    chk("t6_no_rise", 32'(alarm_rise), 0);
    vstep(150);
    chk("t6_still_below", 32'(alarm), 0);
    vstep(150);
    chk("t6_arm", 32'(alarm), 1);
    step(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ave8_thresh.md
Name: ave8_thresh

Overview:
- Downstream consumer of the 8-sample moving-average stage. Watches each new average against a hysteresis window.
- Debounces threshold crossings and raises an alarm level plus one-cycle rise/fall event pulses.
- Tracks the peak average and a saturating count of alarm events, both cleared by software.
- Feeds the status/interrupt logic of the averaging subsystem.

Parameters:
DW, 8, width of the average value and both thresholds
DEB, 3, consecutive qualifying samples needed to change alarm state (legal 1..15)
CW, 8, width of the event counter

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
avg  in  DW  average value from the averaging stage (MSB at index 0)
avg_valid  in  1  one-cycle strobe: avg holds a new average this cycle
thr_hi  in  DW  arm threshold; a sample qualifies when avg > thr_hi (strict)
thr_lo  in  DW  disarm threshold; a sample qualifies when avg < thr_lo (strict)
clr  in  1  synchronous clear of peak and event_cnt
alarm  out  1  registered alarm level
alarm_rise  out  1  one-cycle pulse on alarm 0->1
alarm_fall  out  1  one-cycle pulse on alarm 1->0
peak  out  DW  maximum avg sampled since the last clear or reset
event_cnt  out  CW  number of alarm rises, saturating at all-ones

Behaviour:
- Reset (asynchronous, active-high): FSM=BELOW; debounce count=0; all outputs 0.
  - RESET asserted mid-debounce discards the partial count.
- avg, thr_hi and thr_lo are sampled only in cycles where avg_valid=1. Cycles with avg_valid=0 change no state except through clr.
- FSM states: BELOW, ARMING, ABOVE, DISARMING. dcnt is a 4-bit debounce count.
- BELOW:
  - qualifying sample (avg > thr_hi) with DEB=1 -> ABOVE.
  - qualifying sample otherwise -> ARMING, dcnt=1.
- ARMING:
  - qualifying sample: dcnt+1; when the result reaches DEB -> ABOVE.
  - non-qualifying sample -> BELOW, dcnt=0.
- ABOVE / DISARMING: mirror of BELOW / ARMING, using avg < thr_lo as the qualifying test and BELOW as the target.
- Pulses and alarm:
  - Entering ABOVE: alarm_rise=1 for exactly the next cycle; alarm=1 from the same cycle.
  - Entering BELOW from DISARMING: alarm_fall=1 for the next cycle; alarm=0.
  - Latency from the qualifying avg_valid cycle to the alarm change is 1 clock.
- Equality is non-qualifying: avg==thr_hi does not arm, avg==thr_lo does not disarm.
- Misconfiguration (thr_lo > thr_hi): the comparisons are applied literally. No special handling.
- Peak:
  - On avg_valid, if avg > peak, peak <= avg (registered, 1-cycle latency).
  - peak is unsigned throughout.
- event_cnt:
  - Increments by 1 on each entry into ABOVE.
  - Holds at 2^CW-1 (no wrap).
- clr:
  - peak <= avg if avg_valid in the same cycle, else 0.
  - event_cnt <= 0. clr has priority over a same-cycle rise, so that rise is not counted.
  - The alarm pulse still fires. The FSM is unaffected.
- Threshold changes take effect on the next avg_valid. An in-progress debounce count is kept.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits: BELOW=0, ARMING=1, ABOVE=2, DISARMING=3).
  - DW default of 8, shared with the averaging stage.
- One natural sub-module: ave8_thresh_deb. It contains the FSM plus the debounce counter and outputs the state and a transition strobe.
- Peak and event counter stay in the top.

Test Plan:
- Reset, then DEB=3, thr_hi=100, thr_lo=80; avg=101,120,105 on three avg_valid strobes -> alarm=1 and alarm_rise pulse one cycle after the 3rd strobe; event_cnt=1; peak=120.
- From BELOW: avg=101,101,99,101 -> no alarm (counter restarts at 99). Then avg=100 x5 -> no alarm (equality non-qualifying).
- In ABOVE: avg=79,79,79 -> alarm_fall pulse after the 3rd strobe, alarm=0. avg=80 x4 before that -> alarm stays 1.
- DEB=3, thr_hi=100, thr_lo=80, CW=2: four full arm/disarm cycles (3x avg=150, then 3x avg=10, repeated) -> event_cnt reads 1,2,3,3 (saturation); 4 rise pulses.
- clr asserted on the same cycle as the avg_valid whose strobe completes arming (avg=150) -> event_cnt=0, peak=150, alarm_rise still pulses, alarm=1.
- RESET asserted after two qualifying samples (ARMING, dcnt=2), released, then one avg=150 -> still BELOW, no pulse.
